fm_discriminator: RTL and testbench
===================================

// Module: fm_discriminator
// PURPOSE
//  Parametrised FM discriminator for the SDR receive path. Takes tagged, interleaved offset-binary I/Q ADC samples
//  and pairs them into complex samples. Computes the cross-product frequency estimate d = Q0*I1 - I0*Q1.
//  Optionally applies gain and saturation, then boxcar-decimates by 2^DEC_LOG2.
//  Replaces toggled-clock filter feeding with valid strobes; downstream FIR consumes out/out_valid in the clk domain.
// PARAMETERS
//  DW        10     input sample width (offset binary)
//  OW        10     output width (offset binary)
//  CHW       3      channel tag width
//  I_CH      3'd6   channel tag carrying I samples
//  Q_CH      3'd4   channel tag carrying Q samples
//  GAIN_SHIFT 0     extra left shift of d before slicing (0..DW)
//  DEC_LOG2  1      decimation factor = 2^DEC_LOG2 (0 = no decimation)
// PORTS
//  clk        in   1    system clock; all logic on rising edge
//  rstn       in   1    asynchronous active-low reset
//  en         in   1    sample accept enable
//  in_valid   in   1    X/channel valid this cycle
//  channel    in   CHW  tag of X
//  X          in   DW   ADC sample, offset binary
//  raw_valid  out  1    one-cycle strobe: raw_out updated
//  raw_out    out  OW   undecimated discriminator, offset binary
//  out_valid  out  1    one-cycle strobe: out updated
//  out        out  OW   decimated discriminator, offset binary
//  pair_err   out  1    one-cycle strobe: I/Q sequencing fault
// BEHAVIOUR
//  - Reset (async, any time incl. mid-block): FSM=WAIT_I; history, pipeline, accumulator and primed cleared.
//    raw_out=out=2^(OW-1); raw_valid=out_valid=pair_err=0. In-flight data is discarded.
//  - Accept = en & in_valid. Signed conversion: s = X with MSB inverted (= X - 2^(DW-1)).
//  - Pairing FSM:
//    WAIT_I: I tag -> Icur<=s, go WAIT_Q. Q tag -> pair_err=1, sample dropped, stay.
//    WAIT_Q: Q tag -> pair strobe, go WAIT_I. I tag -> pair_err=1, Icur<=s (newest I wins), stay.
//    Other tags are ignored in both states. en=0 blocks acceptance only; the pipeline keeps draining.
//  - Pair strobe (edge t): I1<=I0, Q1<=Q0, I0<=Icur, Q0<=s; primed<=1.
//    Only the first pair after reset sets primed and produces no raw_valid.
//  - Pipeline: edge t+1 registers both products (2DW signed); t+2 registers d (2DW+1 signed);
//    t+3 updates raw_out with raw_valid=1 for one cycle. Fully pipelined: pairs every 2 clocks sustained.
//  - Slice: v = d >>> (2DW-OW-GAIN_SHIFT) (arithmetic); keep OW LSBs (see CONFIGURATION).
//    raw_out = v with MSB inverted. With GAIN_SHIFT=0 the result never overflows.
//  - Decimator: signed accumulator of OW+DEC_LOG2 bits adds v on each raw_valid; a counter tracks 2^DEC_LOG2 raws.
//    On the last raw: out <= (acc+v)>>>DEC_LOG2 with MSB inverted; out_valid=1 one clock after that raw_valid.
//    Accumulator reloads with 0 the same edge. DEC_LOG2=0: out follows raw_out delayed by 1 clock.
//  - raw_valid and pair_err may assert in the same cycle; they are independent.
// CONFIGURATION
//  FMDISC_SAT_EN defined: v clamps to [-2^(OW-1), 2^(OW-1)-1] when it exceeds OW bits.
//  FMDISC_SAT_EN undefined: v truncates to OW LSBs (two's-complement wrap); no extra logic.
//  Decimator input is the post-clamp/wrap v in both cases.
// TESTING
//  1 Assert rstn=0 mid-stream -> raw_out=out=512, all strobes 0, next I/Q pair treated as first (no raw_valid).
//  2 Defaults; repeat (I=612,Q=512) pairs -> first pair no raw_valid; then raw_out=512 every pair, 3 clk latency.
//  3 Defaults; pair (612,512) then (512,612) -> d=10000, raw_out=521; DEC_LOG2=1 two such -> out=521, 1 out_valid.
//  4 GAIN_SHIFT=2; pair (0,0) then (1023,0) -> d=523776, v=2046 -> SAT_EN: raw_out=1023; no SAT_EN: raw_out=510.
//  5 Sequence I=700, I=612, Q=512 -> pair_err on second I; pair uses I=612. Lone Q in WAIT_I -> pair_err, dropped.
//  6 en=0 while in_valid=1 for 10 samples -> no acceptance, no pair_err; pipeline drains already accepted pairs.

Source files
------------

// File: rtl/fm_discriminator.sv
// FM discriminator: pairs tagged offset-binary I/Q samples, computes Q0*I1 - I0*Q1,
// slices to OW bits and boxcar-decimates by 2^DEC_LOG2. Define FMDISC_SAT_EN to clamp instead of wrap.
module fm_discriminator #(
  parameter int unsigned     DW         = 10,
  parameter int unsigned     OW         = 10,
  parameter int unsigned     CHW        = 3,
  parameter logic [CHW-1:0]  I_CH       = 3'd6,
  parameter logic [CHW-1:0]  Q_CH       = 3'd4,
  parameter int unsigned     GAIN_SHIFT = 0,
  parameter int unsigned     DEC_LOG2   = 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  input  logic           in_valid,
  input  logic [CHW-1:0] channel,
  input  logic [DW-1:0]  X,
  output logic           raw_valid,
  output logic [OW-1:0]  raw_out,
  output logic           out_valid,
  output logic [OW-1:0]  out,
  output logic           pair_err
);

  localparam int unsigned PW   = 2 * DW;
  localparam int unsigned DDW  = 2 * DW + 1;
  localparam int unsigned SW   = DDW + GAIN_SHIFT;
  localparam int unsigned RSH  = 2 * DW - OW;
  localparam int unsigned AW   = OW + DEC_LOG2;
  localparam int unsigned CNTW = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'((1 << DEC_LOG2) - 1);

  typedef enum logic {WAIT_I, WAIT_Q} state_t;

  state_t                state_q;
  logic                  accept;
  logic signed [DW-1:0]  s;
  logic signed [DW-1:0]  icur_q, i0_q, q0_q, i1_q, q1_q;
  logic                  primed_q, pv_q, pair_err_q;

  logic                  pv1_q, pv2_q, raw_valid_q;
  logic signed [PW-1:0]  pa_q, pb_q;
  logic signed [DDW-1:0] d_q;
  logic signed [OW-1:0]  v_q, v_d;
  logic signed [SW-1:0]  sh_l, sh_r;

  logic signed [AW-1:0]  acc_q, sum_d;
  logic [CNTW-1:0]       cnt_q;
  logic signed [OW-1:0]  dec_q;
  logic                  out_valid_q;

  assign accept = en & in_valid;
  assign s      = {~X[DW-1], X[DW-2:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= WAIT_I;
      icur_q     <= '0;
      i0_q       <= '0;
      q0_q       <= '0;
      i1_q       <= '0;
      q1_q       <= '0;
      primed_q   <= 1'b0;
      pv_q       <= 1'b0;
      pair_err_q <= 1'b0;
    end else begin
      pv_q       <= 1'b0;
      pair_err_q <= 1'b0;
      if (accept) begin
        case (state_q)
          WAIT_I: begin
            if (channel == I_CH) begin
              icur_q  <= s;
              state_q <= WAIT_Q;
            end else if (channel == Q_CH) begin
              pair_err_q <= 1'b1;
            end
          end
          WAIT_Q: begin
            if (channel == Q_CH) begin
              i1_q     <= i0_q;
              q1_q     <= q0_q;
              i0_q     <= icur_q;
              q0_q     <= s;
              primed_q <= 1'b1;
              // The very first pair only loads history; it has no predecessor to cross with.
              pv_q     <= primed_q;
              state_q  <= WAIT_I;
            end else if (channel == I_CH) begin
              pair_err_q <= 1'b1;
              icur_q     <= s;
            end
          end
          default: state_q <= WAIT_I;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv1_q       <= 1'b0;
      pv2_q       <= 1'b0;
      raw_valid_q <= 1'b0;
      pa_q        <= '0;
      pb_q        <= '0;
      d_q         <= '0;
      v_q         <= '0;
    end else begin
      pv1_q       <= pv_q;
      pv2_q       <= pv1_q;
      raw_valid_q <= pv2_q;
      if (pv_q) begin
        pa_q <= PW'(q0_q) * PW'(i1_q);
        pb_q <= PW'(i0_q) * PW'(q1_q);
      end
      if (pv1_q) d_q <= DDW'(pa_q) - DDW'(pb_q);
      if (pv2_q) v_q <= v_d;
    end
  end

  // Gain is applied as a left shift before the fixed right shift so GAIN_SHIFT may exceed 2DW-OW.
  always_comb begin
    sh_l = SW'(d_q) <<< GAIN_SHIFT;
    sh_r = sh_l >>> RSH;
`ifdef FMDISC_SAT_EN
    if ((&sh_r[SW-1:OW-1]) | ~(|sh_r[SW-1:OW-1])) begin
      v_d = sh_r[OW-1:0];
    end else begin
      v_d = sh_r[SW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
`else
    v_d = sh_r[OW-1:0];
`endif
  end

`ifndef FMDISC_SAT_EN
  logic unused_sh_hi;
  assign unused_sh_hi = ^sh_r[SW-1:OW];
`endif

  assign sum_d = acc_q + AW'(v_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      dec_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (raw_valid_q) begin
        if (cnt_q == LAST) begin
          dec_q       <= OW'(sum_d >>> DEC_LOG2);
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          cnt_q       <= '0;
        end else begin
          acc_q <= sum_d;
          cnt_q <= cnt_q + CNTW'(1);
        end
      end
    end
  end

  assign raw_valid = raw_valid_q;
  assign raw_out   = {~v_q[OW-1], v_q[OW-2:0]};
  assign out_valid = out_valid_q;
  assign out       = {~dec_q[OW-1], dec_q[OW-2:0]};
  assign pair_err  = pair_err_q;

endmodule

// File: tb/tb_fm_discriminator.sv
// Self-checking bench for fm_discriminator: default instance plus a GAIN_SHIFT=2 instance on shared stimulus.
module tb_fm_discriminator;

  localparam int DW = 10;
  localparam int OW = 10;
  localparam int ICH = 6;
  localparam int QCH = 4;

  logic       clk = 1'b0;
  logic       rstn, en, in_valid;
  logic [2:0] channel;
  logic [9:0] X;
  logic       raw_valid0, out_valid0, pair_err0;
  logic [9:0] raw_out0, out0;
  logic       raw_valid2, out_valid2, pair_err2;
  logic [9:0] raw_out2, out2;

  fm_discriminator u_dut0 (
    .clk(clk), .rstn(rstn), .en(en), .in_valid(in_valid), .channel(channel), .X(X),
    .raw_valid(raw_valid0), .raw_out(raw_out0), .out_valid(out_valid0), .out(out0), .pair_err(pair_err0)
  );

  fm_discriminator #(.GAIN_SHIFT(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .en(en), .in_valid(in_valid), .channel(channel), .X(X),
    .raw_valid(raw_valid2), .raw_out(raw_out2), .out_valid(out_valid2), .out(out2), .pair_err(pair_err2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: transaction-level pairing, arithmetic frequency estimate, boxcar of 2.
  int have_i, icur, have_prev, pi, pq;
  int perr_exp = 0, perr_seen0 = 0, perr_seen2 = 0;
  int acc0, cnt0, acc2, cnt2;
  int qraw0[$], qraw2[$], qout0[$], qout2[$];

  function automatic int slice(input longint d, input int g);
    longint t;
    t = (d * (longint'(1) << g)) >>> (2 * DW - OW);
`ifdef FMDISC_SAT_EN
    if (t > 511) t = 511;
    if (t < -512) t = -512;
`else
    t = t & 1023;
    if (t >= 512) t = t - 1024;
`endif
    return int'(t);
  endfunction

  task automatic model_reset();
    have_i = 0; have_prev = 0; icur = 0; pi = 0; pq = 0;
    acc0 = 0; cnt0 = 0; acc2 = 0; cnt2 = 0;
    qraw0.delete(); qraw2.delete(); qout0.delete(); qout2.delete();
  endtask

  task automatic model_pair(input int i, input int q);
    longint d;
    int v0, v2;
    if (have_prev != 0) begin
      d  = longint'(q) * pi - longint'(i) * pq;
      v0 = slice(d, 0);
      v2 = slice(d, 2);
      qraw0.push_back(v0 + 512);
      qraw2.push_back(v2 + 512);
      acc0 += v0; cnt0++;
      acc2 += v2; cnt2++;
      if (cnt0 == 2) begin qout0.push_back((acc0 >>> 1) + 512); acc0 = 0; cnt0 = 0; end
      if (cnt2 == 2) begin qout2.push_back((acc2 >>> 1) + 512); acc2 = 0; cnt2 = 0; end
    end
    pi = i; pq = q; have_prev = 1;
  endtask

  task automatic model_accept(input int ch, input int x);
    int s;
    s = x - 512;
    if (ch == ICH) begin
      if (have_i != 0) perr_exp++;
      icur = s; have_i = 1;
    end else if (ch == QCH) begin
      if (have_i == 0) perr_exp++;
      else begin
        have_i = 0;
        model_pair(icur, s);
      end
    end
  endtask

  task automatic drive(input bit e, input bit v, input int ch, input int x);
    en = e; in_valid = v; channel = 3'(ch); X = 10'(x);
    if (e && v) model_accept(ch, x);
    @(posedge clk); #1;
    en = 1'b0; in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (raw_valid0) begin
        if (qraw0.size() == 0) chk("raw0_unexpected", 1, 0);
        else chk("raw0_stream", int'(raw_out0), qraw0.pop_front());
      end
      if (raw_valid2) begin
        if (qraw2.size() == 0) chk("raw2_unexpected", 1, 0);
        else chk("raw2_stream", int'(raw_out2), qraw2.pop_front());
      end
      if (out_valid0) begin
        if (qout0.size() == 0) chk("out0_unexpected", 1, 0);
        else chk("out0_stream", int'(out0), qout0.pop_front());
      end
      if (out_valid2) begin
        if (qout2.size() == 0) chk("out2_unexpected", 1, 0);
        else chk("out2_stream", int'(out2), qout2.pop_front());
      end
      if (pair_err0) perr_seen0++;
      if (pair_err2) perr_seen2++;
    end
  end

  // Sends one I/Q pair and waits up to 8 clocks for the raw strobe.
  task automatic send_pair(input int i, input int q, input bit expv, input int r0, input int r2);
    int lat;
    lat = 0;
    drive(1, 1, ICH, i);
    drive(1, 1, QCH, q);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (raw_valid0 && lat == 0) begin
        lat = k;
        if (expv) begin
          chk("pair_raw0", int'(raw_out0), r0);
          chk("pair_raw2", int'(raw_out2), r2);
        end
      end
    end
    chk(expv ? "pair_latency" : "first_pair_noraw", lat, expv ? 3 : 0);
  endtask

  typedef struct {
    int i;
    int q;
    bit expv;
    int raw0;
    int raw2;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nraw, nperr;
    vecs[0] = '{612, 512, 1'b0, 0, 0};
    vecs[1] = '{612, 512, 1'b1, 512, 512};
    vecs[2] = '{512, 612, 1'b1, 521, 551};
    vecs[3] = '{512, 612, 1'b1, 512, 512};
    vecs[4] = '{0, 0, 1'b1, 562, 712};
`ifdef FMDISC_SAT_EN
    vecs[5] = '{1023, 0, 1'b1, 1023, 1023};
`else
    vecs[5] = '{1023, 0, 1'b1, 1023, 510};
`endif

    rstn = 1'b0; en = 1'b0; in_valid = 1'b0; channel = '0; X = '0;
    model_reset();
    #12;
    chk("rst_raw_out", int'(raw_out0), 512);
    chk("rst_out", int'(out0), 512);
    chk("rst_raw_valid", int'(raw_valid0), 0);
    chk("rst_out_valid", int'(out_valid0), 0);
    chk("rst_pair_err", int'(pair_err0), 0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 6; n++)
      send_pair(vecs[n].i, vecs[n].q, vecs[n].expv, vecs[n].raw0, vecs[n].raw2);

    // Newest I wins after a repeated I; lone Q is dropped.
    drive(1, 1, ICH, 700);
    chk("perr_first_i", int'(pair_err0), 0);
    drive(1, 1, ICH, 612);
    chk("perr_second_i", int'(pair_err0), 1);
    drive(1, 1, QCH, 512);
    chk("perr_after_q", int'(pair_err0), 0);
    nraw = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (raw_valid0) begin
        nraw++;
        chk("newest_i_raw0", int'(raw_out0), 562);
        chk("newest_i_raw2", int'(raw_out2), 712);
      end
    end
    chk("newest_i_count", nraw, 1);
    drive(1, 1, QCH, 300);
    chk("lone_q_perr", int'(pair_err0), 1);
    nraw = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (raw_valid0) nraw++;
    end
    chk("lone_q_noraw", nraw, 0);

    // en=0 blocks acceptance while the pipeline drains.
    drive(1, 1, ICH, 612);
    drive(1, 1, QCH, 512);
    nraw = 0; nperr = 0;
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, (k % 2 == 0) ? QCH : ICH, 100 + k);
      if (raw_valid0) nraw++;
      if (pair_err0) nperr++;
    end
    chk("en0_drain_raw", nraw, 1);
    chk("en0_no_perr", nperr, 0);
    chk("en0_raw_value", int'(raw_out0), 512);
    drive(1, 1, QCH, 400);
    chk("en0_state_kept", int'(pair_err0), 1);

    // Reset mid-stream with a pair in flight.
    drive(1, 1, ICH, 800);
    drive(1, 1, QCH, 200);
    rstn = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_raw_out", int'(raw_out0), 512);
    chk("mid_rst_out", int'(out0), 512);
    chk("mid_rst_strobes", int'({raw_valid0, out_valid0, pair_err0}), 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    send_pair(612, 512, 1'b0, 0, 0);
    send_pair(612, 512, 1'b1, 512, 512);

    for (int n = 0; n < 1500; n++) begin
      int r, ch, x;
      r  = int'($urandom_range(0, 9));
      ch = (r < 4) ? ICH : (r < 8) ? QCH : int'($urandom_range(0, 7));
      r  = int'($urandom_range(0, 9));
      x  = (r == 0) ? 0 : (r == 1) ? 1023 : int'($urandom_range(0, 1023));
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, ch, x);
    end
    repeat (12) @(posedge clk);
    #1;
    chk("drain_raw0", qraw0.size(), 0);
    chk("drain_raw2", qraw2.size(), 0);
    chk("drain_out0", qout0.size(), 0);
    chk("drain_out2", qout2.size(), 0);
    chk("perr_count0", perr_seen0, perr_exp);
    chk("perr_count2", perr_seen2, perr_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
